y86_regfile_sb: RTL and testbench
=================================

// Module: y86_regfile_sb
// PURPOSE
//  Parametrised Y86-64 register file for the pipelined core: two combinational read ports (srcA/srcB),
//  two clocked write ports (E from execute result, M from memory load), same-cycle write-to-read bypass,
//  and a per-register pending-write scoreboard that flags read-after-write hazards to the hazard unit.
//  Sits between decode (reads, issue) and write-back (writes); replaces the single-port SEQ register file.
// PARAMETERS
//  DATA_W     64    register width in bits
//  NREGS      15    implemented registers, indices 0..NREGS-1; max 15
//  SP_IDX     4     stack-pointer index (%rsp)
//  STACK_TOP  1023  reset value of register SP_IDX
//  CNT_W      2     pending-write counter width per register
//  BYPASS     1     1 = same-cycle write visible on read port; 0 = read returns stored value only
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  src_a      in   4       read port A index; 4'hF = RNONE
//  src_b      in   4       read port B index; 4'hF = RNONE
//  val_a      out  DATA_W  read data A (combinational)
//  val_b      out  DATA_W  read data B (combinational)
//  busy_a     out  1       src_a has pending write(s) (combinational)
//  busy_b     out  1       src_b has pending write(s) (combinational)
//  iss_valid  in   1       decode issues an instruction this cycle
//  iss_dst_e  in   4       issued instruction's E destination; RNONE = none
//  iss_dst_m  in   4       issued instruction's M destination; RNONE = none
//  we_e       in   1       write-back E valid
//  dst_e      in   4       write-back E index
//  val_e      in   DATA_W  write-back E data
//  we_m       in   1       write-back M valid
//  dst_m      in   4       write-back M index
//  val_m      in   DATA_W  write-back M data
//  err        out  1       sticky error flag, registered
// BEHAVIOUR
//  Reset (rst_n low, async): reg[i]=0 for all i except reg[SP_IDX]=STACK_TOP; all counters=0; err=0.
//  Read: index RNONE or >=NREGS -> value 0, busy 0. Otherwise reg[idx], overridden when BYPASS=1 by
//    val_m if we_m && dst_m==idx, else val_e if we_e && dst_e==idx (M has priority: popq %rsp rule).
//  Write: on rising clk, we_e && dst_e<NREGS -> reg[dst_e]<=val_e; we_m && dst_m<NREGS -> reg[dst_m]<=val_m;
//    same index on both ports -> val_m stored. RNONE writes are silently ignored (no error).
//  Scoreboard: cnt[i] += (iss_valid && iss_dst_e==i) + (iss_valid && iss_dst_m==i)
//    - (we_e && dst_e==i) - (we_m && dst_m==i); net computed in one step, so simultaneous issue and
//    retire on same register leaves cnt unchanged. iss_dst_e==iss_dst_m==i adds 2.
//  busy_x = (cnt[src_x]!=0), minus same-cycle retirements of src_x when BYPASS=1 (value forwarded).
//  err set (next edge, sticky until reset) on: counter overflow (cnt would exceed 2^CNT_W-1; cnt saturates),
//    underflow (retire with cnt==0; cnt stays 0, write still performed), or any non-RNONE index >=NREGS
//    on an issue/write port. Reads of out-of-range indices never set err.
//  Latency: read 0 cycles; write visible in storage 1 cycle after edge; err 1 cycle.
//  Reset mid-operation: all pending counts discarded; in-flight writes after reset release count as underflow
//    -> pipeline must be flushed with reset.
// STRUCTURE
//  Shared package y86_pkg: REG_RNONE=4'hF, REG_RSP=4'h4, REG_IDX_W=4, register-name constants.
//  Sub-module y86_sb_counter: one saturating up/down counter (2 inc, 2 dec inputs, ovf/unf outputs),
//  generated NREGS times. Storage and bypass muxes live in the top.
// TESTING
//  Reset: pulse rst_n low mid-cycle -> val_a(src_a=4)=1023, val_b(src_b=0)=0, err=0 without clk edge.
//  Dual write same reg: we_e,dst_e=4,val_e=0x10; we_m,dst_m=4,val_m=0x20 -> next cycle read 4 = 0x20.
//  Bypass: we_e dst_e=3 val_e=0xABC, src_a=3 same cycle -> val_a=0xABC, busy_a=0 (BYPASS=1); stored 0 if BYPASS=0.
//  Scoreboard: issue dst_e=2 twice (cnt=2), retire once -> busy on 2 stays 1; retire again -> busy 0.
//  Simultaneous issue+retire reg 5 with cnt=1 -> cnt stays 1; RNONE read -> 0, busy 0, no err.
//  Errors: retire dst_e=6 with cnt=0 -> err=1 next cycle, reg6 written; 4 issues to reg 7 (CNT_W=2) -> err=1, sticky.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 register index constants used by the register file and its clients.
package y86_pkg;
   localparam int REG_IDX_W = 4;
   localparam logic [REG_IDX_W-1:0] REG_RAX = 4'h0;
   localparam logic [REG_IDX_W-1:0] REG_RCX = 4'h1;
   localparam logic [REG_IDX_W-1:0] REG_RDX = 4'h2;
   localparam logic [REG_IDX_W-1:0] REG_RBX = 4'h3;
   localparam logic [REG_IDX_W-1:0] REG_RSP = 4'h4;
   localparam logic [REG_IDX_W-1:0] REG_RBP = 4'h5;
   localparam logic [REG_IDX_W-1:0] REG_RSI = 4'h6;
   localparam logic [REG_IDX_W-1:0] REG_RDI = 4'h7;
   localparam logic [REG_IDX_W-1:0] REG_RNONE = 4'hF;
endpackage

// File: rtl/y86_sb_counter.sv
// y86_sb_counter: saturating pending-write counter, two increments and two decrements netted per cycle.
module y86_sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc0,
   input  logic             inc1,
   input  logic             dec0,
   input  logic             dec1,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             unf
);
   localparam int MAX = 2**CNT_W - 1;
   int nxt;
   always_comb begin
      nxt = int'(cnt) + int'(inc0) + int'(inc1) - int'(dec0) - int'(dec1);
      ovf = nxt > MAX;
      unf = nxt < 0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= ovf ? CNT_W'(MAX) : unf ? '0 : nxt[CNT_W-1:0];
endmodule

// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: dual-read, dual-write Y86-64 register file with write bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module y86_regfile_sb
   import y86_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int NREGS     = 15,
   parameter int SP_IDX    = 4,
   parameter int STACK_TOP = 1023,
   parameter int CNT_W     = 2,
   parameter int BYPASS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_IDX_W-1:0] src_a,
   input  logic [REG_IDX_W-1:0] src_b,
   output logic [DATA_W-1:0]    val_a,
   output logic [DATA_W-1:0]    val_b,
   output logic                 busy_a,
   output logic                 busy_b,
   input  logic                 iss_valid,
   input  logic [REG_IDX_W-1:0] iss_dst_e,
   input  logic [REG_IDX_W-1:0] iss_dst_m,
   input  logic                 we_e,
   input  logic [REG_IDX_W-1:0] dst_e,
   input  logic [DATA_W-1:0]    val_e,
   input  logic                 we_m,
   input  logic [REG_IDX_W-1:0] dst_m,
   input  logic [DATA_W-1:0]    val_m,
   output logic                 err
);
   logic [DATA_W-1:0] regs [NREGS];
   logic [CNT_W-1:0]  cnt  [NREGS];
   logic [NREGS-1:0]  ovf, unf;
   logic              bad;

   function automatic logic in_rng(input logic [REG_IDX_W-1:0] i);
      return i != REG_RNONE && int'(i) < NREGS;
   endfunction

   function automatic logic bad_idx(input logic [REG_IDX_W-1:0] i);
      return i != REG_RNONE && int'(i) >= NREGS;
   endfunction

   // M wins over E so that popq %rsp sees the loaded value.
   function automatic logic [DATA_W-1:0] rd_val(input logic [REG_IDX_W-1:0] i);
      if (!in_rng(i)) return '0;
      if (BYPASS != 0 && we_m && dst_m == i) return val_m;
      if (BYPASS != 0 && we_e && dst_e == i) return val_e;
      return regs[i];
   endfunction

   function automatic logic rd_busy(input logic [REG_IDX_W-1:0] i);
      int c;
      if (!in_rng(i)) return 1'b0;
      c = int'(cnt[i]);
      if (BYPASS != 0) c = c - int'(we_e && dst_e == i) - int'(we_m && dst_m == i);
      return c > 0;
   endfunction

   always_comb begin
      val_a  = rd_val(src_a);
      val_b  = rd_val(src_b);
      busy_a = rd_busy(src_a);
      busy_b = rd_busy(src_b);
   end

   assign bad = (iss_valid && (bad_idx(iss_dst_e) || bad_idx(iss_dst_m)))
             || (we_e && bad_idx(dst_e)) || (we_m && bad_idx(dst_m));

   for (genvar g = 0; g < NREGS; g++) begin : g_cnt
      y86_sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk  (clk),
         .rst_n(rst_n),
         .inc0 (iss_valid && int'(iss_dst_e) == g),
         .inc1 (iss_valid && int'(iss_dst_m) == g),
         .dec0 (we_e && int'(dst_e) == g),
         .dec1 (we_m && int'(dst_m) == g),
         .cnt  (cnt[g]),
         .ovf  (ovf[g]),
         .unf  (unf[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= (i == SP_IDX) ? DATA_W'(STACK_TOP) : '0;
      end else begin
         if (we_e && in_rng(dst_e)) regs[dst_e] <= val_e;
         if (we_m && in_rng(dst_m)) regs[dst_m] <= val_m;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else err <= err | (|ovf) | (|unf) | bad;
endmodule

// File: tb/tb_y86_regfile_sb.sv
// tb_y86_regfile_sb: directed checks of reads, writes, bypass, scoreboard and error flag,
// with a second instance built without bypass for comparison.
module tb_y86_regfile_sb;
   import y86_pkg::*;
   logic clk = 1'b0, rst_n;
   logic [3:0] src_a, src_b, iss_dst_e, iss_dst_m, dst_e, dst_m;
   logic iss_valid, we_e, we_m;
   logic [63:0] val_e, val_m, val_a, val_b, nb_val_a, nb_val_b;
   logic busy_a, busy_b, err, nb_busy_a, nb_busy_b, nb_err;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   y86_regfile_sb dut (
      .clk(clk), .rst_n(rst_n), .src_a(src_a), .src_b(src_b), .val_a(val_a), .val_b(val_b),
      .busy_a(busy_a), .busy_b(busy_b), .iss_valid(iss_valid), .iss_dst_e(iss_dst_e),
      .iss_dst_m(iss_dst_m), .we_e(we_e), .dst_e(dst_e), .val_e(val_e), .we_m(we_m),
      .dst_m(dst_m), .val_m(val_m), .err(err)
   );

   y86_regfile_sb #(.BYPASS(0)) nb (
      .clk(clk), .rst_n(rst_n), .src_a(src_a), .src_b(src_b), .val_a(nb_val_a), .val_b(nb_val_b),
      .busy_a(nb_busy_a), .busy_b(nb_busy_b), .iss_valid(iss_valid), .iss_dst_e(iss_dst_e),
      .iss_dst_m(iss_dst_m), .we_e(we_e), .dst_e(dst_e), .val_e(val_e), .we_m(we_m),
      .dst_m(dst_m), .val_m(val_m), .err(nb_err)
   );

   task automatic idle();
      iss_valid = 0; iss_dst_e = REG_RNONE; iss_dst_m = REG_RNONE;
      we_e = 0; dst_e = REG_RNONE; val_e = '0; we_m = 0; dst_m = REG_RNONE; val_m = '0;
      src_a = REG_RNONE; src_b = REG_RNONE;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] e, input logic [3:0] m);
      idle(); iss_valid = 1; iss_dst_e = e; iss_dst_m = m; tick(); idle();
   endtask

   task automatic test_reset();
      idle(); rst_n = 0;
      #12 rst_n = 1;
      tick();
      we_e = 1; dst_e = REG_RSP; val_e = 64'h55;
      tick(); idle(); src_a = REG_RSP; src_b = REG_RAX; #1;
      checks++; if (val_a !== 64'h55) begin errors++; $display("FAIL pre_reset_rsp got %0h exp 55", val_a); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got %0b exp 1", err); end
      #2 rst_n = 0; #1;
      checks++; if (val_a !== 64'd1023) begin errors++; $display("FAIL reset_rsp got %0h exp 3ff", val_a); end
      checks++; if (val_b !== 64'd0) begin errors++; $display("FAIL reset_rax got %0h exp 0", val_b); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
      #3 rst_n = 1;
      tick();
   endtask

   task automatic test_dual_write();
      issue(REG_RSP, REG_RSP);
      we_e = 1; dst_e = REG_RSP; val_e = 64'h10; we_m = 1; dst_m = REG_RSP; val_m = 64'h20; src_a = REG_RSP; #1;
      checks++; if (val_a !== 64'h20) begin errors++; $display("FAIL dual_bypass got %0h exp 20", val_a); end
      checks++; if (nb_val_a !== 64'd1023) begin errors++; $display("FAIL dual_nobypass got %0h exp 3ff", nb_val_a); end
      checks++; if (busy_a !== 1'b0 || nb_busy_a !== 1'b1) begin errors++; $display("FAIL dual_busy got %0b/%0b exp 0/1", busy_a, nb_busy_a); end
      tick(); idle(); src_a = REG_RSP; #1;
      checks++; if (val_a !== 64'h20 || nb_val_a !== 64'h20) begin errors++; $display("FAIL dual_stored got %0h/%0h exp 20", val_a, nb_val_a); end
      checks++; if (busy_a !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL dual_after got busy %0b err %0b exp 0 0", busy_a, err); end
   endtask

   task automatic test_bypass();
      issue(REG_RBX, REG_RNONE);
      we_e = 1; dst_e = REG_RBX; val_e = 64'hABC; src_a = REG_RBX; #1;
      checks++; if (val_a !== 64'hABC || busy_a !== 1'b0) begin errors++; $display("FAIL bypass got %0h busy %0b exp abc 0", val_a, busy_a); end
      checks++; if (nb_val_a !== 64'd0 || nb_busy_a !== 1'b1) begin errors++; $display("FAIL nobypass got %0h busy %0b exp 0 1", nb_val_a, nb_busy_a); end
      tick(); idle(); src_a = REG_RBX; #1;
      checks++; if (val_a !== 64'hABC || nb_val_a !== 64'hABC || nb_busy_a !== 1'b0) begin errors++; $display("FAIL bypass_stored got %0h/%0h busy %0b exp abc 0", val_a, nb_val_a, nb_busy_a); end
   endtask

   task automatic test_scoreboard();
      issue(REG_RDX, REG_RNONE);
      issue(REG_RDX, REG_RNONE);
      src_a = REG_RDX; #1;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL sb_two got %0b exp 1", busy_a); end
      we_e = 1; dst_e = REG_RDX; val_e = 64'h1; #1;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL sb_retire1 got %0b exp 1", busy_a); end
      tick(); idle(); src_a = REG_RDX; #1;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL sb_one got %0b exp 1", busy_a); end
      we_m = 1; dst_m = REG_RDX; val_m = 64'h2; #1;
      checks++; if (busy_a !== 1'b0 || nb_busy_a !== 1'b1) begin errors++; $display("FAIL sb_retire2 got %0b/%0b exp 0/1", busy_a, nb_busy_a); end
      tick(); idle(); src_a = REG_RDX; #1;
      checks++; if (busy_a !== 1'b0 || val_a !== 64'h2) begin errors++; $display("FAIL sb_zero got busy %0b val %0h exp 0 2", busy_a, val_a); end
   endtask

   task automatic test_simul();
      issue(REG_RBP, REG_RNONE);
      iss_valid = 1; iss_dst_e = REG_RBP; we_e = 1; dst_e = REG_RBP; val_e = 64'h5;
      tick(); idle(); src_b = REG_RBP; #1;
      checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL simul_cnt got %0b exp 1", busy_b); end
      we_e = 1; dst_e = REG_RBP; val_e = 64'h6;
      tick(); idle(); src_b = REG_RBP; src_a = REG_RNONE; #1;
      checks++; if (busy_b !== 1'b0 || val_b !== 64'h6) begin errors++; $display("FAIL simul_drain got busy %0b val %0h exp 0 6", busy_b, val_b); end
      checks++; if (val_a !== 64'd0 || busy_a !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rnone got %0h busy %0b err %0b exp 0 0 0", val_a, busy_a, err); end
      we_e = 1; dst_e = REG_RNONE; val_e = 64'h9;
      tick(); idle(); #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnone_write_err got %0b exp 0", err); end
   endtask

   task automatic test_errors();
      we_e = 1; dst_e = REG_RSI; val_e = 64'h66; #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL unf_early got %0b exp 0", err); end
      tick(); idle(); src_a = REG_RSI; #1;
      checks++; if (err !== 1'b1 || val_a !== 64'h66 || busy_a !== 1'b0) begin errors++; $display("FAIL unf got err %0b val %0h busy %0b exp 1 66 0", err, val_a, busy_a); end
      #2 rst_n = 0; #2 rst_n = 1; tick();
      for (int i = 0; i < 3; i++) issue(REG_RDI, REG_RNONE);
      src_a = REG_RDI; #1;
      checks++; if (err !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL ovf_three got err %0b busy %0b exp 0 1", err, busy_a); end
      issue(REG_RDI, REG_RNONE); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf got %0b exp 1", err); end
      for (int i = 0; i < 2; i++) begin
         we_e = 1; dst_e = REG_RDI; val_e = 64'h7; tick(); idle();
      end
      src_a = REG_RDI; #1;
      checks++; if (busy_a !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL sat_sticky got busy %0b err %0b exp 1 1", busy_a, err); end
      we_e = 1; dst_e = REG_RDI; val_e = 64'h8; tick(); idle(); src_a = REG_RDI; #1;
      checks++; if (busy_a !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL sat_drain got busy %0b err %0b exp 0 1", busy_a, err); end
      we_m = 1; dst_m = REG_RCX; val_m = 64'h11; tick(); idle(); src_b = REG_RCX; #1;
      checks++; if (val_b !== 64'h11 || nb_err !== 1'b1) begin errors++; $display("FAIL unf_m got %0h err %0b exp 11 1", val_b, nb_err); end
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_bypass();
      test_scoreboard();
      test_simul();
      test_errors();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
